// File: rtl/ex_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// ex_muldiv_sequencer
//   Iterative RV32M multiply/divide unit sitting beside the EX-stage ALU.
//   An M-extension op in EX stalls the pipeline while a shift-add multiply
//   or a restoring divide runs for XLEN cycles. The result is then held
//   until the pipeline advances. A flush aborts an in-flight op.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   EX holds a valid M op (held high while stalled)
//   funct3   in   MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   a, b     in   forwarded rs1 / rs2 data
//   advance  in   pipeline latches EX->MEM at this edge
//   flush    in   branch recovery, kill the EX instruction
//   stall_ex out  hold IF/ID/EX (combinational)
//   busy     out  multiply or divide iterations in progress
//   done     out  result valid
//   result   out  registered result
// ---------------------------------------------------------------------------
module ex_muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            advance,
    input  logic            flush,
    output logic            stall_ex,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // hi: upper accumulator (mul) or partial remainder (div), one spare bit
    logic [XLEN:0]   hi_q, hi_d;
    // lo: multiplier shifting out (mul) or dividend/quotient (div)
    logic [XLEN-1:0] lo_q, lo_d;
    // opnd: multiplicand (mul) or divisor (div)
    logic [XLEN-1:0] opnd_q, opnd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [2:0]      f3_q, f3_d;
    logic            neg_q, neg_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // operand decode at accept time
    logic            sgn_a, sgn_b, is_div, is_rem, div_zero, div_ovf;
    logic [XLEN-1:0] abs_a, abs_b;

    // multiply step
    logic [XLEN:0]     mul_add;
    logic [2*XLEN-1:0] prod, prod_fix;

    // divide step
    logic [XLEN:0]   rem_sh, rem_trial, div_hi;
    logic            div_ge;
    logic [XLEN-1:0] div_lo, quo_fix, rem_fix;

    always_comb begin
        sgn_a  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b  = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
        is_div = funct3[2];
        is_rem = funct3[2] & funct3[1];
        abs_a  = (sgn_a && a[XLEN-1]) ? -a : a;
        abs_b  = (sgn_b && b[XLEN-1]) ? -b : b;
        div_zero = is_div && (b == '0);
        div_ovf  = is_div && !funct3[0] && (a == SMIN) && (b == '1);

        // add-then-shift: product so far sits in {mul_add, lo[XLEN-1:1]}
        mul_add  = lo_q[0] ? (hi_q + {1'b0, opnd_q}) : hi_q;
        prod     = {mul_add, lo_q[XLEN-1:1]};
        prod_fix = neg_q ? -prod : prod;

        rem_sh    = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        rem_trial = rem_sh - {1'b0, opnd_q};
        div_ge    = rem_sh >= {1'b0, opnd_q};
        div_hi    = div_ge ? rem_trial : rem_sh;
        div_lo    = {lo_q[XLEN-2:0], div_ge};
        quo_fix   = neg_q ? -div_lo : div_lo;
        rem_fix   = neg_q ? -div_hi[XLEN-1:0] : div_hi[XLEN-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        f3_d     = f3_q;
        neg_d    = neg_q;

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    f3_d   = funct3;
                    cnt_d  = '0;
                    hi_d   = '0;
                    neg_d  = is_rem ? (sgn_a & a[XLEN-1])
                                    : ((sgn_a & a[XLEN-1]) ^ (sgn_b & b[XLEN-1]));
                    lo_d   = is_div ? abs_a : abs_b;
                    opnd_d = is_div ? abs_b : abs_a;
                    if (div_zero) begin
                        result_d = funct3[1] ? a : '1;
                        state_d  = S_DONE;
                    end else if (div_ovf) begin
                        result_d = funct3[1] ? '0 : SMIN;
                        state_d  = S_DONE;
                    end else begin
                        state_d = is_div ? S_DIV : S_MUL;
                    end
                end
                S_MUL: begin
                    hi_d  = {1'b0, prod[2*XLEN-1:XLEN]};
                    lo_d  = prod[XLEN-1:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        result_d = (f3_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0]
                                                       : prod_fix[2*XLEN-1:XLEN];
                        state_d  = S_DONE;
                    end
                end
                S_DIV: begin
                    hi_d  = div_hi;
                    lo_d  = div_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        result_d = f3_q[1] ? rem_fix : quo_fix;
                        state_d  = S_DONE;
                    end
                end
                S_DONE: if (advance) begin
                    // start is ignored here so a held-over op is not re-issued
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_MUL) || (state_d == S_DIV);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
            f3_q     <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // DONE releases the stall so EX can move on
    assign stall_ex = start & (state_q != S_DONE) & ~flush & ~rst;
    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;

endmodule
